// File: rtl/wb_cmd_pkg.sv
// Shared types and defaults for the Wishbone command master.
// Holds the FSM state enum, bus widths and timeout defaults.
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WB_AW       = 32;
    localparam int WB_DW       = 32;
    localparam int WB_SW       = WB_DW / 8;
    localparam int TIMEOUT_DEF = 255;
    localparam int TO_W_DEF    = 16;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one bus cycle per command.
// Ports: cmd_* valid/ready command in, rsp_* valid/ready response out,
// wbm_* Wishbone master side, busy_o high outside IDLE.
// Build option WB_CMD_MASTER_ERR_EN adds wbm_err_i as a terminating error.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
`ifdef WB_CMD_MASTER_ERR_EN
    input  logic            wbm_err_i,
`endif
    output logic            busy_o
);

    // Counter value on the last strobe cycle before abort.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DW-1:0]     rsp_dat_q, rsp_dat_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [DW/8-1:0]   sel_q, sel_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              bus_err;
    logic              bus_term;

`ifdef WB_CMD_MASTER_ERR_EN
    assign bus_err = wbm_err_i;
`else
    assign bus_err = 1'b0;
`endif
    assign bus_term = wbm_ack_i | bus_err;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_d        = cmd_we_i;
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    sel_d       = cmd_sel_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    state_d     = BUS;
                end
            end
            BUS: begin
                // A termination on the timeout edge still completes normally.
                if (bus_term) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_err_d   = bus_err;
                    rsp_dat_d   = (bus_err | we_q) ? '0 : wbm_dat_i;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == TO_LAST) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master with a behavioural slave model.
// Runs directed cases then randomized transactions with TIMEOUT=8.
module tb_wb_cmd_master;
    import wb_cmd_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = '0;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT(TMO), .TO_W(16)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (dat_o),
        .wbm_dat_i   (dat_i),
        .wbm_ack_i   (ack),
`ifdef WB_CMD_MASTER_ERR_EN
        .wbm_err_i   (err),
`endif
        .busy_o      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One command through a slave that terminates on strobe cycle
    // 'waits' (0-based); the response is then held off for 'hold' cycles.
    task automatic xfer(input logic we_i, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int waits, input logic [31:0] rdata,
                        input bit inj_err, input int hold);
        bit          term;
        bit          exp_err;
        int          exp_stb;
        logic [31:0] exp_dat;
        int          n;
        int          guard;
        term    = (waits <= TMO - 1);
        exp_err = !term || inj_err;
        exp_stb = term ? waits + 1 : TMO;
        exp_dat = (we_i || exp_err) ? 32'h0 : rdata;

        cmd_we    = we_i;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = s;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            step();
            guard++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        check("accept_busy", {62'd0, busy, cmd_ready}, 64'b10);

        n = 0;
        guard = 0;
        while (stb && guard < 100) begin
            n++;
            check("bus_adr_dat", {adr, dat_o}, {a, d});
            check("bus_ctl", {58'd0, cyc, we, sel}, {58'd0, 1'b1, we_i, s});
            ack   = (n - 1 == waits);
            err   = inj_err && (n - 1 == waits);
            dat_i = (n - 1 == waits) ? rdata : $urandom;
            step();
            guard++;
        end
        ack = 1'b0;
        err = 1'b0;
        check("stb_cycles", 64'(n), 64'(exp_stb));
        check("cyc_drop", 64'(cyc), 64'd0);
        check("rsp", {rsp_valid, rsp_err, 30'd0, rsp_dat},
              {1'b1, exp_err, 30'd0, exp_dat});

        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            step();
            check("hold_rsp", {rsp_valid, rsp_err, 30'd0, rsp_dat},
                  {1'b1, exp_err, 30'd0, exp_dat});
            check("hold_bus", {61'd0, cyc, stb, cmd_ready}, 64'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("release", {61'd0, rsp_valid, cmd_ready, busy}, 64'b010);
    endtask

    initial begin
        bit ie;
        repeat (2) step();
        check("rst_ctl", {56'd0, cmd_ready, rsp_valid, rsp_err, cyc, stb, we, busy, 1'b0},
              {56'd0, 8'b1000_0000});
        check("rst_dat", {rsp_dat, adr}, 64'd0);
        check("rst_sel_do", {28'd0, sel, dat_o}, 64'd0);
        rst = 1'b0;
        step();

        xfer(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0, 0);
        xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 3, 32'h1234_5678, 1'b0, 0);
        xfer(1'b0, 32'h3000_000C, 32'h0, 4'hF, 1000, 32'h5555_AAAA, 1'b0, 0);
        xfer(1'b0, 32'h3000_0010, 32'h0, 4'h3, 2, 32'hCAFE_F00D, 1'b0, 0);
        xfer(1'b1, 32'h3000_0014, 32'h0BAD_CAFE, 4'h5, 1, 32'h0, 1'b0, 5);
        xfer(1'b1, 32'h3000_0018, 32'h1111_2222, 4'hC, 0, 32'h0, 1'b0, 0);
        xfer(1'b0, 32'h3000_001C, 32'h0, 4'hF, TMO - 1, 32'h7777_0001, 1'b0, 0);
        xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, TMO, 32'h7777_0002, 1'b0, 0);
`ifdef WB_CMD_MASTER_ERR_EN
        xfer(1'b0, 32'h3000_0024, 32'h0, 4'hF, 1, 32'h9999_9999, 1'b1, 0);
`endif

        // Reset during the second wait state of a read, then a late ack.
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0040;
        cmd_sel   = 4'hF;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        check("mid_bus", {62'd0, cyc, stb}, 64'b11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid", {59'd0, cyc, stb, rsp_valid, busy, cmd_ready}, 64'b00001);
        check("rst_mid_adr", 64'(adr), 64'd0);
        ack   = 1'b1;
        dat_i = 32'hFFFF_0000;
        step();
        ack = 1'b0;
        check("late_ack", {61'd0, rsp_valid, busy, cyc}, 64'd0);

        for (int k = 0; k < 40; k++) begin
            ie = 1'b0;
`ifdef WB_CMD_MASTER_ERR_EN
            ie = ($urandom_range(0, 3) == 0);
`endif
            xfer(1'($urandom), $urandom, $urandom, 4'($urandom),
                 int'($urandom_range(0, TMO + 2)), $urandom, ie,
                 int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
